// File: rtl/inert_intf.sv
// Inertial sensor interface: SPI master plus init/read sequencer and a
// complementary-style pitch integrator. Gyro pitch rate is integrated and
// pulled toward the accelerometer-derived angle by a fixed +/-1024 step.
module inert_intf #(
    parameter logic [15:0] PTCH_RT_OFFSET = 16'h0050,
    parameter logic [15:0] AZ_OFFSET      = 16'h00A0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    input  logic        MISO,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    output logic        vld,
    output logic [15:0] ptch
);

    typedef enum logic [3:0] {
        INIT1, INIT2, INIT3, INIT4, WAIT_INT,
        RD_PL, RD_PH, RD_AZL, RD_AZH, VLD
    } state_t;

    state_t        state_r;
    logic          int_ff1_r, int_ff2_r;
    logic [15:0]   timer_r;
    logic          wrt_r;
    logic [15:0]   cmd_r;
    logic [8:0]    spi_cnt_r;
    logic [14:0]   tx_r;
    logic [7:0]    rx_r;
    logic          pend_r, done_r;
    logic [7:0]    pitch_l_r, pitch_h_r, az_l_r, az_h_r;
    logic [26:0]   ptch_int_r;

    logic [8:0]    cnt_nxt_s;
    logic          sclk_nxt_s, rise_s, fall_s, frame_end_s, busy_s;
    logic [15:0]   ptch_rt_comp_s, az_comp_s;
    logic signed [25:0] az_ext_s, prod_s, ptch_acc_s, ptch_ext_s;
    logic [26:0]   rt_ext_s, fusion_s;

    // Within a 512-clk frame, SCLK is low for phase 8..23 of every 32 clks:
    // first edge is a fall, 16 rises, and SCLK is back high when SS_n rises.
    always_comb begin
        cnt_nxt_s   = spi_cnt_r + 9'd1;
        sclk_nxt_s  = !((cnt_nxt_s[4:0] >= 5'd8) && (cnt_nxt_s[4:0] <= 5'd23));
        rise_s      = !SS_n && !SCLK && sclk_nxt_s;
        fall_s      = !SS_n && SCLK && !sclk_nxt_s && (cnt_nxt_s[8:5] != 4'd0);
        frame_end_s = !SS_n && (spi_cnt_r == 9'd511);
        busy_s      = wrt_r || !SS_n || pend_r;
    end

    // Integrator datapath: offset removal, accel scaling and fusion direction.
    always_comb begin
        ptch_rt_comp_s = {pitch_h_r, pitch_l_r} - PTCH_RT_OFFSET;
        az_comp_s      = {az_h_r, az_l_r} - AZ_OFFSET;
        az_ext_s       = {{10{az_comp_s[15]}}, az_comp_s};
        prod_s         = az_ext_s * 26'sd327;
        ptch_acc_s     = prod_s >>> 5'd13;
        ptch_ext_s     = {{10{ptch[15]}}, ptch};
        rt_ext_s       = {{11{ptch_rt_comp_s[15]}}, ptch_rt_comp_s};
        if (ptch_acc_s > ptch_ext_s) begin
            fusion_s = 27'd1024;
        end else begin
            fusion_s = 27'h7FFFC00;
        end
    end

    assign ptch = ptch_int_r[26:11];

    // Two-flop synchronizer for the asynchronous data-ready interrupt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_ff1_r <= 1'b0;
            int_ff2_r <= 1'b0;
        end else begin
            int_ff1_r <= INT;
            int_ff2_r <= int_ff1_r;
        end
    end

    // Free-running power-up timer; sensor init waits for it to fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_r <= 16'h0000;
        end else begin
            timer_r <= timer_r + 16'h0001;
        end
    end

    // SPI master: frame launch, shifting on SCLK edges, done one clk after SS_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            SS_n      <= 1'b1;
            SCLK      <= 1'b1;
            MOSI      <= 1'b0;
            spi_cnt_r <= 9'd0;
            tx_r      <= 15'd0;
            rx_r      <= 8'd0;
            pend_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            pend_r <= frame_end_s;
            done_r <= pend_r;
            if (frame_end_s) begin
                SS_n      <= 1'b1;
                SCLK      <= 1'b1;
                MOSI      <= 1'b0;
                spi_cnt_r <= 9'd0;
            end else if (!SS_n) begin
                spi_cnt_r <= cnt_nxt_s;
                SCLK      <= sclk_nxt_s;
                if (rise_s) begin
                    rx_r <= {rx_r[6:0], MISO};
                end
                if (fall_s) begin
                    MOSI <= tx_r[14];
                    tx_r <= {tx_r[13:0], 1'b0};
                end
            end else if (wrt_r) begin
                SS_n      <= 1'b0;
                SCLK      <= 1'b1;
                spi_cnt_r <= 9'd0;
                MOSI      <= cmd_r[15];
                tx_r      <= cmd_r[14:0];
            end
        end
    end

    // Sequencer: init writes, then per-interrupt four reads, capture and integrate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= INIT1;
            wrt_r      <= 1'b0;
            cmd_r      <= 16'h0000;
            vld        <= 1'b0;
            pitch_l_r  <= 8'h00;
            pitch_h_r  <= 8'h00;
            az_l_r     <= 8'h00;
            az_h_r     <= 8'h00;
            ptch_int_r <= 27'd0;
        end else begin
            wrt_r <= 1'b0;
            vld   <= 1'b0;
            case (state_r)
                INIT1: if (timer_r == 16'hFFFF) begin
                    wrt_r <= 1'b1; cmd_r <= 16'h0D02; state_r <= INIT2;
                end
                INIT2: if (done_r) begin
                    wrt_r <= 1'b1; cmd_r <= 16'h1053; state_r <= INIT3;
                end
                INIT3: if (done_r) begin
                    wrt_r <= 1'b1; cmd_r <= 16'h1150; state_r <= INIT4;
                end
                INIT4: if (done_r) begin
                    wrt_r <= 1'b1; cmd_r <= 16'h1460; state_r <= WAIT_INT;
                end
                WAIT_INT: if (int_ff2_r && !busy_s) begin
                    wrt_r <= 1'b1; cmd_r <= 16'hA200; state_r <= RD_PL;
                end
                RD_PL: if (done_r) begin
                    pitch_l_r <= rx_r;
                    wrt_r <= 1'b1; cmd_r <= 16'hA300; state_r <= RD_PH;
                end
                RD_PH: if (done_r) begin
                    pitch_h_r <= rx_r;
                    wrt_r <= 1'b1; cmd_r <= 16'hAC00; state_r <= RD_AZL;
                end
                RD_AZL: if (done_r) begin
                    az_l_r <= rx_r;
                    wrt_r <= 1'b1; cmd_r <= 16'hAD00; state_r <= RD_AZH;
                end
                RD_AZH: if (done_r) begin
                    az_h_r  <= rx_r;
                    state_r <= VLD;
                end
                VLD: begin
                    ptch_int_r <= ptch_int_r + fusion_s - rt_ext_s;
                    vld        <= 1'b1;
                    state_r    <= WAIT_INT;
                end
                default: state_r <= INIT1;
            endcase
        end
    end

endmodule

// File: tb/tb_inert_intf.sv
// Bench for inert_intf: a sensor model answers SPI reads from its register
// values, a scoreboard checks every frame command and every ptch result.
module tb_inert_intf;

    localparam longint RATE_OFF = 80;
    localparam longint AZ_OFF   = 160;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        INT;
    logic        MISO = 1'b0;
    logic        SS_n, SCLK, MOSI, vld;
    logic [15:0] ptch;

    inert_intf dut (
        .clk(clk), .rst_n(rst_n), .INT(INT), .MISO(MISO),
        .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .vld(vld), .ptch(ptch)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int frames_done = 0;
    int first_start = -1;
    int vld_count = 0;
    logic [15:0] cmd_q[$];
    logic [15:0] exp_q[$];
    logic [7:0]  sen_pl, sen_ph, sen_azl, sen_azh;
    longint      m_int = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic longint wrapn(input longint v, input int n);
        longint m = longint'(1) << n;
        longint r = v % m;
        if (r < 0) r = r + m;
        if (r >= m / 2) r = r - m;
        return r;
    endfunction

    function automatic longint fdiv(input longint v, input longint d);
        longint q = v / d;
        if ((v % d) != 0 && v < 0) q = q - 1;
        return q;
    endfunction

    // Reference: one integration step from the raw rate and accel words.
    task automatic model_sample(input logic [15:0] rate, input logic [15:0] az);
        longint rc  = wrapn(wrapn(longint'(rate), 16) - RATE_OFF, 16);
        longint ac  = wrapn(wrapn(longint'(az), 16) - AZ_OFF, 16);
        longint acc = fdiv(ac * 327, 8192);
        longint cur = fdiv(m_int, 2048);
        longint fus = (acc > cur) ? 1024 : -1024;
        m_int = wrapn(m_int - rc + fus, 27);
        exp_q.push_back(16'(fdiv(m_int, 2048)));
    endtask

    function automatic logic [7:0] lookup(input logic [7:0] b);
        case (b)
            8'hA2:   return sen_pl;
            8'hA3:   return sen_ph;
            8'hAC:   return sen_azl;
            8'hAD:   return sen_azh;
            default: return 8'h00;
        endcase
    endfunction

    // Cycle counter since reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Sensor model and frame monitor
    logic        prev_ss = 1'b1, prev_sclk = 1'b1, in_frame = 1'b0;
    int          rises = 0, lowcnt = 0;
    logic [15:0] rx_cmd = 16'h0;
    logic [7:0]  rd_byte = 8'h0;
    always @(negedge clk) begin
        if (!rst_n) begin
            in_frame = 1'b0; MISO = 1'b0; prev_ss = 1'b1; prev_sclk = 1'b1;
        end else begin
            if (prev_ss && !SS_n) begin
                in_frame = 1'b1; rises = 0; lowcnt = 1; rx_cmd = 16'h0;
                if (first_start < 0) first_start = cyc;
            end else if (in_frame && !SS_n) begin
                lowcnt++;
                if (!prev_sclk && SCLK) begin
                    rx_cmd = {rx_cmd[14:0], MOSI};
                    rises++;
                end else if (prev_sclk && !SCLK && rises >= 8 && rises < 16) begin
                    if (rises == 8) rd_byte = lookup(rx_cmd[7:0]);
                    MISO = rd_byte[15 - rises];
                end
            end else if (in_frame && SS_n) begin
                chk("frame_len", lowcnt, 512);
                chk("frame_sclk_rises", rises, 16);
                if (cmd_q.size() == 0) begin
                    chk("frame_unexpected", rx_cmd, 32'hFFFF_FFFF);
                end else begin
                    chk("frame_cmd", rx_cmd, cmd_q.pop_front());
                end
                in_frame = 1'b0; MISO = 1'b0; frames_done++;
            end
            prev_ss = SS_n; prev_sclk = SCLK;
        end
    end

    // Result monitor: vld width and ptch against scoreboard
    logic vld_prev = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (vld_prev) chk("vld_one_clk", vld, 0);
            if (vld) begin
                vld_count++;
                if (exp_q.size() == 0) chk("vld_unexpected", 1, 0);
                else                   chk("ptch", ptch, exp_q.pop_front());
            end
        end
        vld_prev = vld;
    end

    // Run one interrupt-driven sample with the given sensor register contents
    task automatic do_sample(input logic [15:0] rate, input logic [15:0] az, input int idx);
        int n = 0;
        sen_pl = rate[7:0]; sen_ph = rate[15:8];
        sen_azl = az[7:0]; sen_azh = az[15:8];
        cmd_q.push_back(16'hA200); cmd_q.push_back(16'hA300);
        cmd_q.push_back(16'hAC00); cmd_q.push_back(16'hAD00);
        model_sample(rate, az);
        @(negedge clk); INT = 1'b1;
        while (SS_n && n < 20) begin @(negedge clk); n++; end
        chk("int_starts_read", SS_n, 0);
        INT = 1'b0;
        n = 0;
        while (vld_count < idx + 1 && n < 3000) begin @(negedge clk); n++; end
        chk("vld_arrives", vld_count, idx + 1);
    endtask

    initial begin
        int n;
        int ss_viol;
        logic [15:0] r1, r2;
        rst_n = 1'b0; INT = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_ss_n", SS_n, 1); chk("rst_sclk", SCLK, 1); chk("rst_mosi", MOSI, 0);
        chk("rst_vld", vld, 0);   chk("rst_ptch", ptch, 0);
        cmd_q.push_back(16'h0D02); cmd_q.push_back(16'h1053);
        cmd_q.push_back(16'h1150); cmd_q.push_back(16'h1460);
        rst_n = 1'b1;

        n = 0;
        while (frames_done < 4 && n < 70000) begin @(posedge clk); n++; end
        chk("init_frames", frames_done, 4);
        chk("first_frame_after_timer", (first_start >= 65535 && first_start <= 65545), 1);
        repeat (20) @(posedge clk);

        do_sample(16'h0050, 16'h00A0, 0);   // at rest: zero compensated rate and accel
        do_sample(16'h8000, 16'h7FFF, 1);   // rate compensation wraps, max accel
        do_sample(16'h0150, 16'h00A0, 2);   // constant positive rate
        for (int i = 3; i < 6; i++) begin
            r1 = 16'($urandom); r2 = 16'($urandom);
            do_sample(r1, r2, i);
        end

        // Reset in the middle of a read frame
        sen_pl = 8'h12; sen_ph = 8'h34; sen_azl = 8'h56; sen_azh = 8'h78;
        @(negedge clk); INT = 1'b1;
        n = 0;
        while (SS_n && n < 20) begin @(negedge clk); n++; end
        chk("mid_read_started", SS_n, 0);
        INT = 1'b0;
        repeat (100) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ss_n", SS_n, 1); chk("midrst_sclk", SCLK, 1); chk("midrst_mosi", MOSI, 0);
        chk("midrst_vld", vld, 0);   chk("midrst_ptch", ptch, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ss_viol = 0;
        repeat (1000) begin @(negedge clk); if (!SS_n) ss_viol++; end
        chk("post_reset_ss_idle", ss_viol, 0);

        chk("cmd_q_drained", cmd_q.size(), 0);
        chk("exp_q_drained", exp_q.size(), 0);
        chk("vld_total", vld_count, 6);
        chk("frames_total", frames_done, 28);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
